fib_display_checker: RTL
========================

// Module: fib_display_checker
// PURPOSE
// Receive-side monitor for the fibfsm seven-segment outputs: decodes out0..out3 back into a
// 16-bit hex word and debounces it. Each settled word is treated as one Fibonacci term and
// checked against the sum of the two previous terms (mod 2^16).
// Sits beside fibfsm in the regfile lab: on-board self-check and bench scoreboard.
// PARAMETERS
// STABLE_CYCLES  4  cycles a decoded word must hold unchanged before it is accepted (1..255)
// STRICT_SEED    1  1: first two accepted terms must be 0 then 1; 0: any two terms seed
// RESYNC_ZERO    1  1: an unexpected term of 0 while tracking restarts seeding, not an error
// PORTS
// clk          in   1   system clock, all logic on rising edge
// reset        in   1   synchronous, active-high; clears all state
// seg0         in   7   digit 0 (least significant nibble), {g,f,e,d,c,b,a}, active-high
// seg1..seg3   in   7   digits 1..3, same encoding; seg3 is most significant
// term         out  16  last accepted decoded word
// term_valid   out  1   one-cycle pulse when term updates
// term_count   out  16  accepted terms since reset/resync, saturates at 16'hFFFF
// tracking     out  1   high once two seeds are accepted and the sequence is being checked
// error        out  1   sticky until reset
// err_code     out  2   00 none, 01 illegal segment pattern, 10 sequence mismatch, 11 bad seed
// BEHAVIOUR
// - Reset: all outputs 0; FSM -> IDLE; stable counter, prev1, prev2 and candidate cleared.
// - Decode, per digit (hex seg -> nibble): 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8
//   6F=9 77=A 7C=b 39=C 5E=d 79=E 71=F. Any other pattern is illegal.
// - seg0..seg3 registered once (stage 1). Decoded word + illegal flag compared to candidate.
// - Debounce: if stage-1 word differs from candidate -> candidate := word, counter := 0.
//   Otherwise counter increments and saturates. At counter == STABLE_CYCLES-1 the candidate
//   is accepted once. Further identical cycles do not re-accept.
// - Latency: inputs constant from cycle T -> term_valid high in cycle T+STABLE_CYCLES+1.
// - Illegal candidate accepted -> error=1, err_code=01; term/term_valid not updated; FSM unchanged.
// - FSM states: IDLE, SEED1, TRACK, FAIL.
//   IDLE: accept w. If STRICT_SEED and w!=0 -> FAIL(11). Else prev1:=w -> SEED1.
//   SEED1: accept w. If STRICT_SEED and w!=1 -> FAIL(11). Else prev2:=prev1, prev1:=w -> TRACK.
//   TRACK: exp = prev1+prev2 (16-bit, carry dropped).
//     Skip rule: if exp==prev1 the term is invisible on the display (e.g. 1,1). The checker then
//     advances internally (prev2:=prev1) and recomputes exp in the next cycle before comparing.
//     At most one skip per accepted word.
//     w==exp -> prev2:=prev1, prev1:=w, stay in TRACK.
//     w!=exp, w==0, RESYNC_ZERO -> prev1:=0, term_count:=1, error unchanged -> SEED1.
//     otherwise -> FAIL(10).
//   FAIL: term/term_valid keep updating; no checking; leaves only on reset.
// - error/err_code: the first error's code wins. Later errors do not overwrite it.
// - term_valid pulses for every accepted legal word in every state, including FAIL.
// - term_count increments per accepted legal word. tracking = (state==TRACK).
// - Reset while a word is being debounced discards it; no term_valid on the reset cycle.
// - A word change on the cycle of acceptance restarts debounce; the accepted word still counts.
// TESTING
// 1 Reset, drive 0000,0001,0002,0003,0005,0008,000D (each 10 cyc) -> 7 term_valid pulses,
//   tracking high after 0001, error=0, term=16'h000D, term_count=7
// 2 Drive 0000,0001,0002 then 0004 -> error=1, err_code=10, FSM FAIL; later words still pulse
// 3 Drive seg0=7'h00 (blank) for 10 cyc -> err_code=01; a 2-cycle 7'h00 glitch -> no error
// 4 Stable 0005 with STRICT_SEED=1 from reset -> err_code=11; STRICT_SEED=0 -> seeds, no error
// 5 Tracking at 0015, drive 0000 -> term_count=1, SEED1; then 0001,0002 -> tracking, error=0
// 6 Words held 3 cycles (STABLE_CYCLES=4) -> no term_valid; held 4 -> pulse at T+5;
//   reset mid-debounce -> no pulse

Source files
------------

// File: rtl/fib_display_checker.sv
// Receive-side monitor for the fibfsm seven-segment display: decodes and debounces the
// four digits into a 16-bit word and checks each settled word as the next Fibonacci term.
module fib_display_checker #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter bit          STRICT_SEED   = 1'b1,
   parameter bit          RESYNC_ZERO   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg0,
   input  logic [6:0]  seg1,
   input  logic [6:0]  seg2,
   input  logic [6:0]  seg3,
   output logic [15:0] term,
   output logic        term_valid,
   output logic [15:0] term_count,
   output logic        tracking,
   output logic        error,
   output logic [1:0]  err_code
);

   typedef enum logic [1:0] {IDLE = 2'd0, SEED1 = 2'd1, TRACK = 2'd2, FAIL = 2'd3} state_t;

   localparam logic [7:0] ACCEPT_AT = 8'(STABLE_CYCLES - 1);

   // Returns {illegal, nibble}
   function automatic logic [4:0] seg_decode(input logic [6:0] s);
      case (s)
         7'h3F: seg_decode = 5'h00;
         7'h06: seg_decode = 5'h01;
         7'h5B: seg_decode = 5'h02;
         7'h4F: seg_decode = 5'h03;
         7'h66: seg_decode = 5'h04;
         7'h6D: seg_decode = 5'h05;
         7'h7D: seg_decode = 5'h06;
         7'h07: seg_decode = 5'h07;
         7'h7F: seg_decode = 5'h08;
         7'h6F: seg_decode = 5'h09;
         7'h77: seg_decode = 5'h0A;
         7'h7C: seg_decode = 5'h0B;
         7'h39: seg_decode = 5'h0C;
         7'h5E: seg_decode = 5'h0D;
         7'h79: seg_decode = 5'h0E;
         7'h71: seg_decode = 5'h0F;
         default: seg_decode = 5'h10;
      endcase
   endfunction

   logic [27:0] segs_q;
   logic [15:0] cand_q, cand_d;
   logic        cand_ill_q, cand_ill_d;
   logic [7:0]  cnt_q, cnt_d;
   state_t      state_q, state_d;
   logic [15:0] prev1_q, prev1_d, prev2_q, prev2_d;
   logic [15:0] term_q, term_d, count_q, count_d;
   logic        tv_q, tv_d, tracking_q, tracking_d, err_q, err_d;
   logic [1:0]  code_q, code_d;

   logic [4:0]  dec0_s, dec1_s, dec2_s, dec3_s;
   logic [15:0] word_s, p2_eff_s, exp_s;
   logic        ill_s, differ_s, accept_s;

   // Decode the registered digits and run the debounce counter
   always_comb begin
      dec0_s   = seg_decode(segs_q[6:0]);
      dec1_s   = seg_decode(segs_q[13:7]);
      dec2_s   = seg_decode(segs_q[20:14]);
      dec3_s   = seg_decode(segs_q[27:21]);
      word_s   = {dec3_s[3:0], dec2_s[3:0], dec1_s[3:0], dec0_s[3:0]};
      ill_s    = dec0_s[4] | dec1_s[4] | dec2_s[4] | dec3_s[4];
      differ_s = (word_s != cand_q) || (ill_s != cand_ill_q);
      if (differ_s) begin
         cand_d     = word_s;
         cand_ill_d = ill_s;
         cnt_d      = 8'd0;
      end else begin
         cand_d     = cand_q;
         cand_ill_d = cand_ill_q;
         cnt_d      = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end
      // Accept only on the edge that reaches the threshold, never while sitting on it
      accept_s = (cnt_d == ACCEPT_AT) && (differ_s || (cnt_d != cnt_q));
   end

   // Sequence checker; a zero prev2 means the duplicated term (1,1) was never displayed
   always_comb begin
      p2_eff_s   = (prev2_q == 16'd0) ? prev1_q : prev2_q;
      exp_s      = prev1_q + p2_eff_s;
      state_d    = state_q;
      prev1_d    = prev1_q;
      prev2_d    = prev2_q;
      term_d     = term_q;
      tv_d       = 1'b0;
      count_d    = count_q;
      err_d      = err_q;
      code_d     = code_q;
      if (accept_s && ill_s) begin
         err_d  = 1'b1;
         code_d = err_q ? code_q : 2'b01;
      end else if (accept_s) begin
         term_d  = word_s;
         tv_d    = 1'b1;
         count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
         case (state_q)
            IDLE: begin
               if (STRICT_SEED && (word_s != 16'd0)) begin
                  state_d = FAIL;
                  err_d   = 1'b1;
                  code_d  = err_q ? code_q : 2'b11;
               end else begin
                  prev1_d = word_s;
                  state_d = SEED1;
               end
            end
            SEED1: begin
               if (STRICT_SEED && (word_s != 16'd1)) begin
                  state_d = FAIL;
                  err_d   = 1'b1;
                  code_d  = err_q ? code_q : 2'b11;
               end else begin
                  prev2_d = prev1_q;
                  prev1_d = word_s;
                  state_d = TRACK;
               end
            end
            TRACK: begin
               if (word_s == exp_s) begin
                  prev2_d = prev1_q;
                  prev1_d = word_s;
               end else if (RESYNC_ZERO && (word_s == 16'd0)) begin
                  prev1_d = 16'd0;
                  count_d = 16'd1;
                  state_d = SEED1;
               end else begin
                  state_d = FAIL;
                  err_d   = 1'b1;
                  code_d  = err_q ? code_q : 2'b10;
               end
            end
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
      tracking_d = (state_d == TRACK);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         segs_q     <= {4{7'h3F}};
         cand_q     <= 16'd0;
         cand_ill_q <= 1'b0;
         cnt_q      <= 8'd0;
         state_q    <= IDLE;
         prev1_q    <= 16'd0;
         prev2_q    <= 16'd0;
         term_q     <= 16'd0;
         tv_q       <= 1'b0;
         count_q    <= 16'd0;
         tracking_q <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= 2'b00;
      end else begin
         segs_q     <= {seg3, seg2, seg1, seg0};
         cand_q     <= cand_d;
         cand_ill_q <= cand_ill_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         prev1_q    <= prev1_d;
         prev2_q    <= prev2_d;
         term_q     <= term_d;
         tv_q       <= tv_d;
         count_q    <= count_d;
         tracking_q <= tracking_d;
         err_q      <= err_d;
         code_q     <= code_d;
      end
   end

   assign term       = term_q;
   assign term_valid = tv_q;
   assign term_count = count_q;
   assign tracking   = tracking_q;
   assign error      = err_q;
   assign err_code   = code_q;

endmodule
